// File: rtl/gray_code_converter_pipe.sv
// Pipelined Gray-code converter: bin2gray, gray2bin, Gray increment and Gray decrement
// behind a valid/ready stream with a combinational ready chain for full throughput.
module gray_code_converter_pipe #(
  parameter int DATA_WIDTH  = 4,
  parameter int PIPE_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [1:0]            mode_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            mode_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  typedef enum logic [1:0] {
    MODE_B2G = 2'b00,
    MODE_G2B = 2'b01,
    MODE_INC = 2'b10,
    MODE_DEC = 2'b11
  } mode_e;

  logic [DATA_WIDTH-1:0] bin_of_in;
  logic [DATA_WIDTH-1:0] inc_bin;
  logic [DATA_WIDTH-1:0] dec_bin;
  logic [DATA_WIDTH-1:0] gray_of_in;
  logic [DATA_WIDTH-1:0] gray_of_inc;
  logic [DATA_WIDTH-1:0] gray_of_dec;
  logic [DATA_WIDTH-1:0] conv_data;

  // Gray->binary is a prefix XOR from the MSB; binary->Gray is a neighbour XOR.
  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_conv_bit
      assign bin_of_in[gi] = ^data_i[DATA_WIDTH-1:gi];
      if (gi == DATA_WIDTH - 1) begin : g_msb
        assign gray_of_in[gi]  = data_i[gi];
        assign gray_of_inc[gi] = inc_bin[gi];
        assign gray_of_dec[gi] = dec_bin[gi];
      end else begin : g_lsb
        assign gray_of_in[gi]  = data_i[gi] ^ data_i[gi+1];
        assign gray_of_inc[gi] = inc_bin[gi] ^ inc_bin[gi+1];
        assign gray_of_dec[gi] = dec_bin[gi] ^ dec_bin[gi+1];
      end
    end
  endgenerate

  // Modular arithmetic gives the wrap between Gray(2^N-1) and 0 for free.
  assign inc_bin = bin_of_in + DATA_WIDTH'(1);
  assign dec_bin = bin_of_in - DATA_WIDTH'(1);

  always_comb begin
    conv_data = gray_of_in;
    case (mode_e'(mode_i))
      MODE_B2G: conv_data = gray_of_in;
      MODE_G2B: conv_data = bin_of_in;
      MODE_INC: conv_data = gray_of_inc;
      MODE_DEC: conv_data = gray_of_dec;
      default:  conv_data = gray_of_in;
    endcase
  end

  logic [PIPE_STAGES-1:0] valid_reg;
  logic [DATA_WIDTH-1:0]  data_reg       [PIPE_STAGES];
  logic [1:0]             mode_reg       [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] stage_in_valid;
  logic [DATA_WIDTH-1:0]  stage_in_data  [PIPE_STAGES];
  logic [1:0]             stage_in_mode  [PIPE_STAGES];
  logic [PIPE_STAGES:0]   stage_adv;
  logic                   in_fire;

  // A stage may load when it is empty or the stage after it is moving on.
  always_comb begin
    stage_adv = '0;
    stage_adv[PIPE_STAGES] = ready_i;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      stage_adv[k] = !valid_reg[k] || stage_adv[k+1];
    end
  end

  assign ready_o = !rst_i && stage_adv[0];
  assign in_fire = valid_i && ready_o;

  generate
    for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage_src
      if (gi == 0) begin : g_head
        assign stage_in_valid[gi] = in_fire;
        assign stage_in_data[gi]  = conv_data;
        assign stage_in_mode[gi]  = mode_i;
      end else begin : g_body
        assign stage_in_valid[gi] = valid_reg[gi-1];
        assign stage_in_data[gi]  = data_reg[gi-1];
        assign stage_in_mode[gi]  = mode_reg[gi-1];
      end
    end
  endgenerate

  // Payload only loads with a valid entry, so bubbles do not toggle the data path.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        valid_reg[k] <= 1'b0;
        data_reg[k]  <= '0;
        mode_reg[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        if (stage_adv[k]) begin
          valid_reg[k] <= stage_in_valid[k];
          if (stage_in_valid[k]) begin
            data_reg[k] <= stage_in_data[k];
            mode_reg[k] <= stage_in_mode[k];
          end
        end
      end
    end
  end

  assign valid_o = valid_reg[PIPE_STAGES-1];
  assign data_o  = data_reg[PIPE_STAGES-1];
  assign mode_o  = mode_reg[PIPE_STAGES-1];

endmodule

// File: tb/tb_gray_code_converter_pipe.sv
// Directed vector table plus backpressure, mid-stream reset and random stress
// for gray_code_converter_pipe, each result checked against a reference model.
module tb_gray_code_converter_pipe;

  localparam int W = 4;
  localparam int P = 2;
  localparam int SW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_i;
  logic [W-1:0] data_i;
  logic [1:0]   mode_i;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] data_o;
  logic [1:0]   mode_o;
  logic         valid_o;
  logic         ready_i;

  int tests = 0;
  int fails = 0;
  int n_out = 0;

  gray_code_converter_pipe #(.DATA_WIDTH(W), .PIPE_STAGES(P)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .mode_i(mode_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_o(data_o), .mode_o(mode_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  function automatic logic [31:0] m_b2g(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] m_g2b(input logic [31:0] g);
    logic [31:0] r;
    r = '0;
    r[31] = g[31];
    for (int i = 30; i >= 0; i--) r[i] = r[i+1] ^ g[i];
    return r;
  endfunction

  function automatic logic [31:0] m_conv(input logic [1:0] m, input logic [31:0] d, input int w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    case (m)
      2'b00:   return m_b2g(d);
      2'b01:   return m_g2b(d);
      2'b10:   return m_b2g((m_g2b(d) + 32'h1) & mask);
      default: return m_b2g((m_g2b(d) - 32'h1) & mask);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Scoreboard for the main instance: inputs queued on accept, results checked on emit.
  typedef struct {
    logic [1:0]   m;
    logic [W-1:0] d;
  } txn_t;
  txn_t exp_q[$];

  always @(negedge clk) begin
    txn_t t;
    txn_t n;
    #1;
    if (rst_i) begin
      exp_q.delete();
    end else begin
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got data %h mode %0d, required no output", data_o, mode_o);
        end else begin
          t = exp_q.pop_front();
          check("out_data", 32'(data_o), m_conv(t.m, 32'(t.d), W));
          check("out_mode", 32'(mode_o), 32'(t.m));
          if (t.m[1]) begin
            check("hamming", 32'($countones(data_o ^ t.d)), 32'd1);
            check("roundtrip", m_g2b(32'(data_o)),
                  (m_g2b(32'(t.d)) + (t.m[0] ? 32'd15 : 32'd1)) & 32'hF);
          end
          n_out++;
          $display("[TB] out #%0d mode=%0d in=%h result=%h", n_out, t.m, t.d, data_o);
        end
      end
      if (valid_i && ready_o) begin
        n.m = mode_i;
        n.d = data_i;
        exp_q.push_back(n);
      end
    end
  end

  // Stress instances share one stimulus; each keeps its own scoreboard.
  logic          s_valid_i = 1'b0;
  logic          s_ready_i = 1'b1;
  logic [SW-1:0] s_data_i  = '0;
  logic [1:0]    s_mode_i  = '0;
  logic          s_ready_o [3];
  logic          s_valid_o [3];
  logic [SW-1:0] s_data_o  [3];
  logic [1:0]    s_mode_o  [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_stress
      localparam int SP = (gi == 0) ? 1 : (gi == 1) ? 3 : 4;
      logic [17:0] q[$];

      gray_code_converter_pipe #(.DATA_WIDTH(SW), .PIPE_STAGES(SP)) u_dut (
        .clk_i(clk), .rst_i(rst_i), .data_i(s_data_i), .mode_i(s_mode_i), .valid_i(s_valid_i),
        .ready_o(s_ready_o[gi]), .data_o(s_data_o[gi]), .mode_o(s_mode_o[gi]),
        .valid_o(s_valid_o[gi]), .ready_i(s_ready_i)
      );

      always @(negedge clk) begin
        logic [17:0] t;
        #1;
        if (rst_i) begin
          q.delete();
        end else begin
          if (s_valid_o[gi] && s_ready_i) begin
            if (q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL stress_p%0d_unexpected: got data %h, required no output", SP, s_data_o[gi]);
            end else begin
              t = q.pop_front();
              check($sformatf("stress_p%0d_data", SP), 32'(s_data_o[gi]), m_conv(t[17:16], 32'(t[15:0]), SW));
              check($sformatf("stress_p%0d_mode", SP), 32'(s_mode_o[gi]), 32'(t[17:16]));
            end
          end
          if (s_valid_i && s_ready_o[gi]) q.push_back({s_mode_i, s_data_i});
        end
      end
    end
  endgenerate

  typedef struct {
    logic [1:0] m;
    logic [3:0] din;
    logic [3:0] dout;
  } vec_t;
  vec_t vecs[12];

  int           idx;
  int           acc;
  int           start_out;
  bit           saw_full;
  bit           have_prev;
  bit           stall;
  logic [W-1:0] prev_d;
  logic [1:0]   prev_m;

  initial begin
    vecs[0]  = '{2'b00, 4'b1011, 4'b1110};
    vecs[1]  = '{2'b01, 4'b1110, 4'b1011};
    vecs[2]  = '{2'b10, 4'b1000, 4'b0000};
    vecs[3]  = '{2'b11, 4'b0000, 4'b1000};
    vecs[4]  = '{2'b10, 4'b0000, 4'b0001};
    vecs[5]  = '{2'b00, 4'b1111, 4'b1000};
    vecs[6]  = '{2'b01, 4'b1000, 4'b1111};
    vecs[7]  = '{2'b01, 4'b0110, 4'b0100};
    vecs[8]  = '{2'b10, 4'b0001, 4'b0011};
    vecs[9]  = '{2'b11, 4'b0011, 4'b0001};
    vecs[10] = '{2'b10, 4'b0110, 4'b0111};
    vecs[11] = '{2'b11, 4'b1100, 4'b0100};

    // Reset held two cycles with valid_i high.
    rst_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1; data_i = 4'hA; mode_i = 2'b00;
    repeat (2) begin
      @(negedge clk);
      check("rst_ready", 32'(ready_o), 32'd0);
      check("rst_valid", 32'(valid_o), 32'd0);
    end
    rst_i = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    check("idle_valid", 32'(valid_o), 32'd0);
    check("idle_data", 32'(data_o), 32'd0);
    check("idle_mode", 32'(mode_o), 32'd0);
    check("idle_ready", 32'(ready_o), 32'd1);

    // Table vectors: one operand at a time, result exactly PIPE_STAGES cycles later.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      valid_i = 1'b1; data_i = vecs[i].din; mode_i = vecs[i].m; ready_i = 1'b1;
      check("vec_accept", 32'(ready_o), 32'd1);
      @(negedge clk);
      valid_i = 1'b0;
      check("vec_latency_early", 32'(valid_o), 32'd0);
      @(negedge clk);
      check("vec_valid", 32'(valid_o), 32'd1);
      check("vec_data", 32'(data_o), 32'(vecs[i].dout));
      check("vec_mode", 32'(mode_o), 32'(vecs[i].m));
    end

    // Exhaustive inc/dec sweep, back to back at full rate.
    for (int m = 2; m < 4; m++) begin
      for (int d = 0; d < 16; d++) begin
        @(negedge clk);
        valid_i = 1'b1; data_i = 4'(d); mode_i = 2'(m);
        check("sweep_ready", 32'(ready_o), 32'd1);
      end
    end
    @(negedge clk);
    valid_i = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
    check("sweep_drain", 32'(exp_q.size()), 32'd0);

    // Backpressure: 8 operands, ready_i low for cycles 3..10.
    start_out = n_out; idx = 0; saw_full = 1'b0; have_prev = 1'b0;
    for (int cyc = 0; cyc < 40 && (idx < 8 || exp_q.size() != 0); cyc++) begin
      @(negedge clk);
      if (have_prev) begin
        check("stall_valid", 32'(valid_o), 32'd1);
        check("stall_data", 32'(data_o), 32'(prev_d));
        check("stall_mode", 32'(mode_o), 32'(prev_m));
      end
      stall   = (cyc >= 3 && cyc <= 10);
      ready_i = !stall;
      valid_i = (idx < 8);
      data_i  = 4'(idx * 3 + 1);
      mode_i  = 2'(idx);
      #1;
      have_prev = valid_o && !ready_i;
      prev_d = data_o;
      prev_m = mode_o;
      if (stall && valid_o && !ready_o) saw_full = 1'b1;
      if (valid_i && ready_o) idx++;
    end
    @(negedge clk);
    valid_i = 1'b0; ready_i = 1'b1;
    repeat (2) @(negedge clk);
    check("bp_ready_fell", 32'(saw_full), 32'd1);
    check("bp_out_count", 32'(n_out - start_out), 32'd8);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset while two results are held behind a stalled output.
    acc = 0;
    for (int c = 0; c < 10 && !(acc == 2 && valid_o); c++) begin
      @(negedge clk);
      ready_i = 1'b0; valid_i = (acc < 2); data_i = 4'(9 + acc); mode_i = 2'b10;
      #1;
      if (valid_i && ready_o) acc++;
    end
    check("mid_accepted", 32'(acc), 32'd2);
    @(negedge clk);
    valid_i = 1'b0;
    check("mid_stalled_valid", 32'(valid_o), 32'd1);
    check("mid_full_ready", 32'(ready_o), 32'd0);
    rst_i = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", 32'(ready_o), 32'd0);
    rst_i = 1'b0; ready_i = 1'b1;
    @(negedge clk);
    check("post_rst_data", 32'(data_o), 32'd0);
    check("post_rst_ready", 32'(ready_o), 32'd1);
    repeat (4) begin
      check("post_rst_valid", 32'(valid_o), 32'd0);
      @(negedge clk);
    end

    // Random stress on the 16-bit instances.
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      s_valid_i = 1'($urandom_range(0, 1));
      s_ready_i = ($urandom_range(0, 9) < 7);
      s_mode_i  = 2'($urandom_range(0, 3));
      s_data_i  = 16'($urandom_range(0, 65535));
    end
    // Full throughput while ready_i is held high.
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      s_ready_i = 1'b1; s_valid_i = 1'b1;
      s_mode_i  = 2'($urandom_range(0, 3));
      s_data_i  = 16'($urandom_range(0, 65535));
      #1;
      for (int k = 0; k < 3; k++) check($sformatf("stress_throughput_%0d", k), 32'(s_ready_o[k]), 32'd1);
    end
    @(negedge clk);
    s_valid_i = 1'b0;
    repeat (8) @(negedge clk);
    check("stress_p1_drain", 32'(g_stress[0].q.size()), 32'd0);
    check("stress_p3_drain", 32'(g_stress[1].q.size()), 32'd0);
    check("stress_p4_drain", 32'(g_stress[2].q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gray_code_converter_pipe.md
# gray_code_converter_pipe

Pipelined, parametrised Gray-code conversion unit with a valid/ready stream interface. Each transaction selects one of four per-transaction operations: binary→Gray, Gray→binary, Gray increment or Gray decrement. It sits between pointer/counter logic and clock-domain-crossing registers, for example async FIFO pointer generation and pointer decode. It supports full throughput with backpressure.

## Interface
- DATA_WIDTH, 4, operand/result width in bits; legal range 2..32.
- PIPE_STAGES, 2, number of register stages; legal range 1..4; latency equals PIPE_STAGES cycles.

Ports:
- clk_i  input  1  clock; all logic is on the rising edge.
- rst_i  input  1  one clock; reset is synchronous and active-high.
- data_i  input  DATA_WIDTH  operand.
- mode_i  input  2  operation select:
  - 00 bin2gray
  - 01 gray2bin
  - 10 gray_inc
  - 11 gray_dec
- valid_i  input  1  operand valid.
- ready_o  output  1  unit can accept an operand this cycle.
- data_o  output  DATA_WIDTH  result.
- mode_o  output  2  mode that produced data_o, carried through the pipe.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts the result.

## Operation
- Conversion is combinational on data_i/mode_i and is captured into stage 1 on an input handshake (valid_i && ready_o). Stages 2..PIPE_STAGES only delay the result.
- bin2gray: g[i] = b[i] ^ b[i+1]; g[MSB] = b[MSB].
- gray2bin: b[MSB] = g[MSB]; b[i] = b[i+1] ^ g[i] (prefix XOR from MSB down).
- gray_inc: result = bin2gray((gray2bin(data_i) + 1) mod 2^DATA_WIDTH). Wraps from Gray(2^N−1) to 0.
- gray_dec: result = bin2gray((gray2bin(data_i) − 1) mod 2^DATA_WIDTH). Wraps from 0 to Gray(2^N−1).
- In gray_inc and gray_dec, exactly one bit of the result differs from data_i for every input, including the wrap. This is the property CDC users rely on.
- Each stage k holds {valid_k, data_k, mode_k}. Stage k advances when its valid is clear or stage k+1 can accept. The last stage advances on ready_i.
- ready_o = !valid_1 || stage 1 advances this cycle. The ready chain is combinational from ready_i, so a full pipe with ready_i=1 accepts one operand per cycle.
- Outputs are driven directly from the last stage: valid_o = valid_last, data_o = data_last, mode_o = mode_last.
- Stall: while valid_o && !ready_i, data_o and mode_o are held stable and valid_o stays high. No stage overwrites a valid entry.
- The unit accepts operands while valid_o is stalled until every stage holds a valid entry. After that ready_o is 0.
- Input values while valid_i=0 are ignored. The unit drops and duplicates nothing; results leave in acceptance order.

## Timing
- Reset (rst_i high at a rising edge): all valid_k cleared, all data_k and mode_k set to 0. From the next cycle: valid_o=0, data_o=0, mode_o=00, ready_o=1.
- While rst_i is high, ready_o is 0 and no handshake occurs on either side. A reset asserted mid-operation discards all in-flight results.
- Latency: an operand accepted at edge t gives valid_o=1 with its result after edge t+PIPE_STAGES−1. It is visible in the cycle following edge t+PIPE_STAGES−1, assuming no stall.
- Throughput: 1 result per cycle while ready_i=1.
- Simultaneous accept and emit in the same cycle with a full pipe: the last stage emits, every stage shifts, stage 1 loads the new operand, and occupancy is unchanged.
- Maximum in-flight results: PIPE_STAGES.

## Test plan
- Reset and idle, PIPE_STAGES=2: assert rst_i for 2 cycles with valid_i=1 -> ready_o=0 during reset, no output. After reset: valid_o=0, data_o=0, ready_o=1.
- Conversions, DATA_WIDTH=4, ready_i=1:
  - bin2gray 4'b1011 -> 4'b1110.
  - gray2bin 4'b1110 -> 4'b1011.
  - Each result appears exactly 2 cycles after acceptance, and mode_o echoes the input mode.
- Wrap-around, DATA_WIDTH=4:
  - gray_inc 4'b1000 -> 4'b0000.
  - gray_dec 4'b0000 -> 4'b1000.
  - gray_inc 4'b0000 -> 4'b0001.
  - Exhaustive sweep over all 16 codes in both directions: every result has Hamming distance 1 from its input and round-trips through gray2bin to ±1 mod 16.
- Backpressure: stream 8 operands with ready_i=0 from cycle 3 to cycle 10 -> ready_o falls once 2 results are held, data_o stays stable while stalled, and all 8 results arrive in order with none lost or duplicated.
- Reset mid-stream: assert rst_i while 2 results are in flight and valid_o is stalled -> valid_o=0 the cycle after reset, and the discarded results never appear.
- Random stress, DATA_WIDTH=16, PIPE_STAGES in {1,3,4}: random valid_i/ready_i/mode_i against a reference scoreboard -> zero mismatches and full throughput whenever ready_i is held at 1.
